// File: rtl/spec_commit_buffer.sv
// In-order commit buffer for speculatively tagged data words.
// Only entries resolved as commit-ok can ever reach out_data.
module spec_commit_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         res_valid,
    input  logic [TAG_W-1:0]             res_tag,
    input  logic                         res_misspec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         squash_pulse
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        E_EMPTY = 2'd0,
        E_PEND  = 2'd1,
        E_OK    = 2'd2,
        E_SQ    = 2'd3
    } ent_st_t;

    ent_st_t           r_st     [DEPTH];
    ent_st_t           w_st_nxt [DEPTH];
    logic [DATA_W-1:0] r_data   [DEPTH];
    logic [TAG_W-1:0]  r_tag    [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_squash;

    ent_st_t           w_head_st;
    logic              w_enq;
    logic              w_deq;
    logic              w_bypass;
    logic              w_any_sq;

    // Head decode: outputs depend only on registered head state, never on res_*
    always_comb begin
        w_head_st = r_st[r_head];
        out_valid = (w_head_st == E_OK);
        out_data  = out_valid ? r_data[r_head] : '0;
        w_deq     = ((w_head_st == E_OK) && out_ready)
                  || (w_head_st == E_SQ);
        in_ready  = (r_count < DEPTH_C);
        w_enq     = in_valid && in_ready;
    end

    // Per-entry next state: resolve pending entries, retire head, fill tail
    always_comb begin
        w_any_sq = 1'b0;
        w_bypass = res_valid && (in_tag == res_tag);
        for (int i = 0; i < DEPTH; i++) begin
            w_st_nxt[i] = r_st[i];
            if ((r_st[i] == E_PEND) && res_valid
                && (r_tag[i] == res_tag)) begin
                w_st_nxt[i] = res_misspec ? E_SQ : E_OK;
                if (res_misspec)
                    w_any_sq = 1'b1;
            end
            if (w_deq && (PW'(i) == r_head))
                w_st_nxt[i] = E_EMPTY;
            if (w_enq && (PW'(i) == r_tail)) begin
                if (w_bypass) begin
                    w_st_nxt[i] = res_misspec ? E_SQ : E_OK;
                    if (res_misspec)
                        w_any_sq = 1'b1;
                end else begin
                    w_st_nxt[i] = E_PEND;
                end
            end
        end
    end

    // Entry state, payload, pointers and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_st[i]   <= E_EMPTY;
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_squash <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                r_st[i] <= w_st_nxt[i];
            if (w_enq) begin
                r_data[r_tail] <= in_data;
                r_tag[r_tail]  <= in_tag;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_deq)
                r_head <= r_head + 1'b1;
            r_count  <= r_count + CW'(w_enq) - CW'(w_deq);
            r_squash <= w_any_sq;
        end
    end

    assign count        = r_count;
    assign squash_pulse = r_squash;

endmodule

// File: tb/tb_spec_commit_buffer.sv
// Bench for spec_commit_buffer: directed scenarios plus randomized
// traffic compared against a queue-based model of the buffer.
module tb_spec_commit_buffer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_tag;
    logic       res_valid;
    logic [3:0] res_tag;
    logic       res_misspec;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       squash_pulse;

    int n_total = 0;
    int n_pass  = 0;

    spec_commit_buffer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag),
        .res_valid(res_valid), .res_tag(res_tag),
        .res_misspec(res_misspec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count),
        .squash_pulse(squash_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: queue of occupied entries, st 1=pending 2=ok 3=squashed
    typedef struct {
        logic [7:0] d;
        logic [3:0] t;
        int         st;
    } ent_t;

    ent_t       q[$];
    logic       m_sp;
    logic [7:0] got[$];

    function automatic logic m_valid();
        return (q.size() > 0) && (q[0].st == 2);
    endfunction

    function automatic logic [7:0] m_data();
        return m_valid() ? q[0].d : 8'h00;
    endfunction

    task automatic m_step();
        ent_t e;
        bit   sq;
        bit   enq;
        sq  = 0;
        enq = in_valid && (q.size() < 4);
        if (q.size() > 0)
            if ((q[0].st == 2 && out_ready) || q[0].st == 3)
                void'(q.pop_front());
        if (res_valid)
            foreach (q[i])
                if (q[i].st == 1 && q[i].t == res_tag) begin
                    q[i].st = res_misspec ? 3 : 2;
                    if (res_misspec) sq = 1;
                end
        if (enq) begin
            e.d  = in_data;
            e.t  = in_tag;
            e.st = 1;
            if (res_valid && in_tag == res_tag) begin
                e.st = res_misspec ? 3 : 2;
                if (res_misspec) sq = 1;
            end
            q.push_back(e);
        end
        m_sp = sq;
    endtask

    task automatic drive(input logic iv, input logic [7:0] d,
                         input logic [3:0] t, input logic rv,
                         input logic [3:0] rt, input logic rm,
                         input logic ordy);
        in_valid    = iv;
        in_data     = d;
        in_tag      = t;
        res_valid   = rv;
        res_tag     = rt;
        res_misspec = rm;
        out_ready   = ordy;
    endtask

    task automatic tick();
        #3;
        if (out_valid && out_ready)
            got.push_back(out_data);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 8'h00, 4'h0, 0, 4'h0, 0, 0);
        #12;
        n_total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00
            || in_ready !== 1'b1 || squash_pulse !== 1'b0)
            $display("FAIL reset_init: cnt=%0d ov=%b od=%h ir=%b sp=%b want 0 0 00 1 0",
                     count, out_valid, out_data, in_ready, squash_pulse);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_sp = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h60 + 8'(i), 4'h1, 0, 4'h0, 0, 0);
            tick();
        end
        drive(0, 8'h00, 4'h0, 1, 4'h1, 0, 0);
        tick();
        drive(0, 8'h00, 4'h0, 0, 4'h0, 0, 0);
        n_total++;
        if (count !== 3'd3 || out_valid !== 1'b1 || out_data !== 8'h60)
            $display("FAIL reset_prefill: cnt=%0d ov=%b od=%h want 3 1 60",
                     count, out_valid, out_data);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00
            || in_ready !== 1'b1 || squash_pulse !== 1'b0)
            $display("FAIL reset_async: cnt=%0d ov=%b od=%h ir=%b sp=%b want 0 0 00 1 0",
                     count, out_valid, out_data, in_ready, squash_pulse);
        else n_pass++;
        q.delete();
        m_sp = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_commit();
        drive(1, 8'hA5, 4'h3, 0, 4'h0, 0, 0);
        tick();
        drive(1, 8'hC3, 4'h3, 0, 4'h0, 0, 0);
        tick();
        drive(0, 8'h00, 4'h0, 1, 4'h3, 0, 0);
        tick();
        drive(0, 8'h00, 4'h0, 0, 4'h0, 0, 1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5)
            $display("FAIL commit_first: ov=%b od=%h want 1 a5", out_valid, out_data);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3 || count !== 3'd1)
            $display("FAIL commit_second: ov=%b od=%h cnt=%0d want 1 c3 1",
                     out_valid, out_data, count);
        else n_pass++;
        tick();
        n_total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL commit_drain: cnt=%0d ov=%b od=%h want 0 0 00",
                     count, out_valid, out_data);
        else n_pass++;
    endtask

    task automatic test_squash();
        drive(1, 8'h11, 4'h1, 0, 4'h0, 0, 1);
        tick();
        drive(1, 8'h22, 4'h2, 0, 4'h0, 0, 1);
        tick();
        drive(1, 8'h33, 4'h1, 0, 4'h0, 0, 1);
        tick();
        drive(0, 8'h00, 4'h0, 1, 4'h1, 1, 1);
        tick();
        n_total++;
        if (squash_pulse !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL squash_pulse_on: sp=%b ov=%b od=%h want 1 0 00",
                     squash_pulse, out_valid, out_data);
        else n_pass++;
        drive(0, 8'h00, 4'h0, 1, 4'h2, 0, 1);
        tick();
        drive(0, 8'h00, 4'h0, 0, 4'h0, 0, 1);
        n_total++;
        if (squash_pulse !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h22
            || count !== 3'd2)
            $display("FAIL squash_keep22: sp=%b ov=%b od=%h cnt=%0d want 0 1 22 2",
                     squash_pulse, out_valid, out_data, count);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== 3'd1)
            $display("FAIL squash_hide33: ov=%b od=%h cnt=%0d want 0 00 1",
                     out_valid, out_data, count);
        else n_pass++;
        tick();
        n_total++;
        if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL squash_drain: cnt=%0d ov=%b want 0 0", count, out_valid);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [7:0] exp_ord [5];
        exp_ord[0] = 8'h70;
        exp_ord[1] = 8'h71;
        exp_ord[2] = 8'h72;
        exp_ord[3] = 8'h73;
        exp_ord[4] = 8'h80;
        got.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'h70 + 8'(i), 4'h7, 0, 4'h0, 0, 0);
            tick();
        end
        n_total++;
        if (in_ready !== 1'b0 || count !== 3'd4)
            $display("FAIL full_ready: ir=%b cnt=%0d want 0 4", in_ready, count);
        else n_pass++;
        drive(1, 8'h80, 4'h7, 1, 4'h7, 0, 1);
        tick();
        n_total++;
        if (count !== 3'd4 || in_ready !== 1'b0 || out_data !== 8'h70)
            $display("FAIL full_block: cnt=%0d ir=%b od=%h want 4 0 70",
                     count, in_ready, out_data);
        else n_pass++;
        drive(1, 8'h80, 4'h7, 0, 4'h0, 0, 1);
        tick();
        n_total++;
        if (count !== 3'd3 || in_ready !== 1'b1)
            $display("FAIL full_free: cnt=%0d ir=%b want 3 1", count, in_ready);
        else n_pass++;
        tick();
        drive(0, 8'h00, 4'h0, 1, 4'h7, 0, 1);
        tick();
        drive(0, 8'h00, 4'h0, 0, 4'h0, 0, 1);
        for (int i = 0; i < 3; i++) tick();
        n_total++;
        if (got.size() != 5 || count !== 3'd0)
            $display("FAIL full_total: accepted=%0d cnt=%0d want 5 0",
                     got.size(), count);
        else n_pass++;
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_total++;
            if (got[i] !== exp_ord[i])
                $display("FAIL full_order%0d: got %h want %h", i, got[i], exp_ord[i]);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        drive(1, 8'h5A, 4'h9, 1, 4'h9, 1, 1);
        tick();
        drive(0, 8'h00, 4'h0, 0, 4'h0, 0, 1);
        n_total++;
        if (count !== 3'd1 || squash_pulse !== 1'b1 || out_valid !== 1'b0
            || out_data !== 8'h00)
            $display("FAIL bypass_sq: cnt=%0d sp=%b ov=%b od=%h want 1 1 0 00",
                     count, squash_pulse, out_valid, out_data);
        else n_pass++;
        tick();
        n_total++;
        if (count !== 3'd0 || squash_pulse !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL bypass_drop: cnt=%0d sp=%b ov=%b want 0 0 0",
                     count, squash_pulse, out_valid);
        else n_pass++;
        drive(1, 8'hB7, 4'hB, 1, 4'hB, 0, 0);
        tick();
        drive(0, 8'h00, 4'h0, 0, 4'h0, 0, 1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'hB7 || squash_pulse !== 1'b0)
            $display("FAIL bypass_ok: ov=%b od=%h sp=%b want 1 b7 0",
                     out_valid, out_data, squash_pulse);
        else n_pass++;
        tick();
    endtask

    task automatic test_pending_head();
        drive(1, 8'h44, 4'h5, 0, 4'h0, 0, 1);
        tick();
        drive(0, 8'h00, 4'h0, 1, 4'h6, 0, 1);
        tick();
        drive(0, 8'h00, 4'h0, 0, 4'h0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== 3'd1)
                $display("FAIL pend_hold%0d: ov=%b od=%h cnt=%0d want 0 00 1",
                         i, out_valid, out_data, count);
            else n_pass++;
            tick();
        end
        drive(0, 8'h00, 4'h0, 1, 4'h5, 0, 1);
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL pend_same_cycle: ov=%b want 0", out_valid);
        else n_pass++;
        tick();
        drive(0, 8'h00, 4'h0, 0, 4'h0, 0, 1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'h44)
            $display("FAIL pend_release: ov=%b od=%h want 1 44", out_valid, out_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive(($urandom_range(0, 9) < 6), 8'($urandom),
                  4'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
                  4'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) < 7));
            n_total++;
            if (in_ready !== (q.size() < 4))
                $display("FAIL rnd_in_ready c%0d: got %b want %b",
                         c, in_ready, (q.size() < 4));
            else n_pass++;
            tick();
            n_total++;
            if (out_valid !== m_valid())
                $display("FAIL rnd_out_valid c%0d: got %b want %b",
                         c, out_valid, m_valid());
            else n_pass++;
            n_total++;
            if (out_data !== m_data())
                $display("FAIL rnd_out_data c%0d: got %h want %h",
                         c, out_data, m_data());
            else n_pass++;
            n_total++;
            if (count !== 3'(q.size()))
                $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, q.size());
            else n_pass++;
            n_total++;
            if (squash_pulse !== m_sp)
                $display("FAIL rnd_squash c%0d: got %b want %b", c, squash_pulse, m_sp);
            else n_pass++;
        end
    endtask

    initial begin
        m_sp = 0;
        test_reset();
        test_commit();
        test_squash();
        test_full();
        test_bypass();
        test_pending_head();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
